// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage.
// Covers ALU opcodes, forward selects, control-bundle bit indices and the E-register bundle.
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 9;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_RES_HI   = 7;
    localparam int CTRL_RES_LO   = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_JUMP     = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_VALID    = 1;
    localparam int CTRL_X0RS     = 0;

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcp4;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        aluc;
    } id_ex_t;

    // MEM wins over WB; a write to x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] rd_m,
        input logic            rw_m,
        input logic [RA_W-1:0] rd_w,
        input logic            rw_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rw_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (rw_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational RAW-hazard forward-select logic for the EX stage.
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic [RA_W-1:0] i_rs1_e,
    input  logic [RA_W-1:0] i_rs2_e,
    input  logic [RA_W-1:0] i_rd_m,
    input  logic            i_regwrite_m,
    input  logic [RA_W-1:0] i_rd_w,
    input  logic            i_regwrite_w,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b
);

    assign o_fwd_a = fwd_sel(i_rs1_e, i_rd_m, i_regwrite_m,
                             i_rd_w, i_regwrite_w);
    assign o_fwd_b = fwd_sel(i_rs2_e, i_rd_m, i_regwrite_m,
                             i_rd_w, i_regwrite_w);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and forwarded EX operand selection.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcp4_d,
    input  logic [RA_W-1:0]   rs1_d,
    input  logic [RA_W-1:0]   rs2_d,
    input  logic [RA_W-1:0]   rd_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [2:0]        alucontrol_d,
    input  logic [XLEN-1:0]   aluresult_m,
    input  logic [RA_W-1:0]   rd_m,
    input  logic              regwrite_m,
    input  logic [XLEN-1:0]   result_w,
    input  logic [RA_W-1:0]   rd_w,
    input  logic              regwrite_w,
    output logic [XLEN-1:0]   srca_e,
    output logic [XLEN-1:0]   srcb_e,
    output logic [XLEN-1:0]   writedata_e,
    output logic [2:0]        alucontrol_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcp4_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [RA_W-1:0]   rs1_e,
    output logic [RA_W-1:0]   rs2_e,
    output logic [RA_W-1:0]   rd_e,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    id_ex_t          w_d;
    id_ex_t          r_e;
    logic [XLEN-1:0] w_srca;
    logic [XLEN-1:0] w_wdata;

    assign w_d = '{rd1:  rd1_d,
                   rd2:  rd2_d,
                   imm:  imm_d,
                   pc:   pc_d,
                   pcp4: pcp4_d,
                   rs1:  rs1_d,
                   rs2:  rs2_d,
                   rd:   rd_d,
                   ctrl: ctrl_d,
                   aluc: alucontrol_d};

    // A flush clears valid and regwrite along with everything else.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_e <= '0;
        end else if (flush_e) begin
            r_e <= '0;
        end else if (!stall_e) begin
            r_e <= w_d;
        end
    end

    forward_unit u_fwd (
        .i_rs1_e      (r_e.rs1),
        .i_rs2_e      (r_e.rs2),
        .i_rd_m       (rd_m),
        .i_regwrite_m (regwrite_m),
        .i_rd_w       (rd_w),
        .i_regwrite_w (regwrite_w),
        .o_fwd_a      (fwd_a),
        .o_fwd_b      (fwd_b)
    );

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] wb,
        input logic [XLEN-1:0] mem
    );
        logic [XLEN-1:0] v;
        case (sel)
            FWD_RF:  v = rf;
            FWD_WB:  v = wb;
            FWD_MEM: v = mem;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_srca  = fwd_mux(fwd_a, r_e.rd1, result_w, aluresult_m);
    assign w_wdata = fwd_mux(fwd_b, r_e.rd2, result_w, aluresult_m);

    assign srca_e       = w_srca;
    assign writedata_e  = w_wdata;
    assign srcb_e       = r_e.ctrl[CTRL_ALUSRC] ? r_e.imm : w_wdata;
    assign alucontrol_e = r_e.aluc;
    assign ctrl_e       = r_e.ctrl;
    assign pc_e         = r_e.pc;
    assign pcp4_e       = r_e.pcp4;
    assign imm_e        = r_e.imm;
    assign rs1_e        = r_e.rs1;
    assign rs2_e        = r_e.rs2;
    assign rd_e         = r_e.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage with a behavioural model and directed anchors.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_e, flush_e;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pcp4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [8:0]  ctrl_d;
    logic [2:0]  alucontrol_d;
    logic [31:0] aluresult_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        regwrite_m, regwrite_w;
    logic [31:0] srca_e, srcb_e, writedata_e, pc_e, pcp4_e, imm_e;
    logic [2:0]  alucontrol_e;
    logic [8:0]  ctrl_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [1:0]  fwd_a, fwd_b;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 1'b0;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
        .pcp4_d(pcp4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .ctrl_d(ctrl_d), .alucontrol_d(alucontrol_d),
        .aluresult_m(aluresult_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .result_w(result_w), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .srca_e(srca_e), .srcb_e(srcb_e), .writedata_e(writedata_e),
        .alucontrol_e(alucontrol_e), .ctrl_e(ctrl_e), .pc_e(pc_e),
        .pcp4_e(pcp4_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently held in E.
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pcp4;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [8:0]  m_ctrl;
    logic [2:0]  m_aluc;

    always @(posedge clk) begin
        if (!reset_n || flush_e) begin
            m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_pc <= 0; m_pcp4 <= 0;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_ctrl <= 0; m_aluc <= 0;
        end else if (!stall_e) begin
            m_rd1 <= rd1_d; m_rd2 <= rd2_d; m_imm <= imm_d;
            m_pc <= pc_d; m_pcp4 <= pcp4_d;
            m_rs1 <= rs1_d; m_rs2 <= rs2_d; m_rd <= rd_d;
            m_ctrl <= ctrl_d; m_aluc <= alucontrol_d;
        end
    end

    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] rs,
                                            input logic [31:0] rf);
        logic [1:0] s;
        s = exp_sel(rs);
        if (s == 2'b10) return aluresult_m;
        if (s == 2'b01) return result_w;
        return rf;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] wd;
            wd = exp_val(m_rs2, m_rd2);
            chk("fwd_a", 32'(fwd_a), 32'(exp_sel(m_rs1)));
            chk("fwd_b", 32'(fwd_b), 32'(exp_sel(m_rs2)));
            chk("srca_e", srca_e, exp_val(m_rs1, m_rd1));
            chk("writedata_e", writedata_e, wd);
            chk("srcb_e", srcb_e, m_ctrl[2] ? m_imm : wd);
            chk("ctrl_e", 32'(ctrl_e), 32'(m_ctrl));
            chk("alucontrol_e", 32'(alucontrol_e), 32'(m_aluc));
            chk("pc_e", pc_e, m_pc);
            chk("pcp4_e", pcp4_e, m_pcp4);
            chk("imm_e", imm_e, m_imm);
            chk("rs1_e", 32'(rs1_e), 32'(m_rs1));
            chk("rs2_e", 32'(rs2_e), 32'(m_rs2));
            chk("rd_e", 32'(rd_e), 32'(m_rd));
        end
    end

    task automatic rand_d();
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
        pc_d = $urandom; pcp4_d = pc_d + 4;
        rs1_d = 5'($urandom_range(0, 3));
        rs2_d = 5'($urandom_range(0, 3));
        rd_d = 5'($urandom); ctrl_d = 9'($urandom);
        alucontrol_d = 3'($urandom);
    endtask

    task automatic rand_mw();
        aluresult_m = $urandom; result_w = $urandom;
        rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
        regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
    endtask

    task automatic quiet_mw();
        regwrite_m = 0; regwrite_w = 0; rd_m = 0; rd_w = 0;
        aluresult_m = 32'hDEAD0001; result_w = 32'hDEAD0002;
    endtask

    // Wait for the edge that loads the driven inputs, then settle mid-cycle.
    task automatic step_check();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic drive_slot();
        @(posedge clk); #2;
    endtask

    initial begin
        reset_n = 0; stall_e = 0; flush_e = 0;
        rand_d(); rand_mw();
        @(posedge clk); #2;
        cmp_en = 1;
        rand_d(); rand_mw();
        step_check();
        chk("rst_srca", srca_e, 32'h0);
        chk("rst_srcb", srcb_e, 32'h0);
        chk("rst_ctrl", 32'(ctrl_e), 32'h0);
        chk("rst_pc", pc_e, 32'h0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);

        drive_slot();
        reset_n = 1; quiet_mw();
        rd1_d = 5; rd2_d = 7; rs1_d = 1; rs2_d = 2; ctrl_d = 9'h002;
        step_check();
        chk("load_srca", srca_e, 32'd5);
        chk("load_srcb", srcb_e, 32'd7);

        drive_slot();
        rs1_d = 3; rd1_d = 32'h99;
        regwrite_m = 1; rd_m = 3; aluresult_m = 32'h10;
        regwrite_w = 1; rd_w = 3; result_w = 32'h20;
        step_check();
        chk("mem_prio_fwd_a", 32'(fwd_a), 32'h2);
        chk("mem_prio_srca", srca_e, 32'h10);

        drive_slot();
        rs2_d = 0; rd2_d = 32'h55; ctrl_d = 9'h002;
        regwrite_m = 1; rd_m = 0; aluresult_m = 32'hFF; regwrite_w = 0;
        step_check();
        chk("x0_fwd_b", 32'(fwd_b), 32'h0);
        chk("x0_srcb", srcb_e, 32'h55);

        drive_slot();
        quiet_mw(); pc_d = 32'h100; ctrl_d = 9'h1FB; rd1_d = 32'h42;
        rs1_d = 1; rs2_d = 2;
        step_check();
        for (int i = 0; i < 3; i++) begin
            drive_slot();
            stall_e = 1; rand_d();
            step_check();
            chk("stall_pc", pc_e, 32'h100);
            chk("stall_srca", srca_e, 32'h42);
        end
        drive_slot();
        stall_e = 1; flush_e = 1;
        step_check();
        chk("flush_ctrl", 32'(ctrl_e), 32'h0);

        drive_slot();
        stall_e = 0; flush_e = 0; quiet_mw();
        ctrl_d = 9'h006; imm_d = 32'hFFFFFFFC; rs2_d = 4; rd2_d = 32'h11;
        regwrite_w = 1; rd_w = 4; result_w = 32'hABCD;
        step_check();
        chk("imm_srcb", srcb_e, 32'hFFFFFFFC);
        chk("wb_wdata", writedata_e, 32'hABCD);

        for (int i = 0; i < 400; i++) begin
            drive_slot();
            reset_n = ($urandom_range(0, 49) != 0);
            flush_e = ($urandom_range(0, 9) == 0);
            stall_e = ($urandom_range(0, 5) == 0);
            rand_d(); rand_mw();
        end
        @(posedge clk); @(negedge clk); #1;
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
